// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts (overlapping) occurrences of a latched
// bit pattern across a frame of valid/ready qualified serial bits.
module pattern_scan_ctrl #(
  parameter int PAT_LEN = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow,
  output logic               done
);

  localparam int SW = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_nx;
  logic [FRAME_W-1:0] len_q;
  logic [FRAME_W-1:0] cnt;
  logic [SW-1:0]      seen;
  logic [SW-1:0]      seen_nx;
  logic               take;
  logic               last;
  logic               hit;
  logic               go;
  logic               go_zero;

  always_comb begin
    take    = (state == SCAN) && din_valid && !abort;
    last    = (cnt == len_q - FRAME_W'(1));
    hist_nx = {hist[PAT_LEN-2:0], din};
    seen_nx = (seen == SW'(PAT_LEN)) ? seen : seen + SW'(1);
    hit     = take && (seen_nx == SW'(PAT_LEN)) && (hist_nx == pat_q);
    go      = (state == IDLE) && start;
    go_zero = go && (frame_len == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    din_ready = (state == SCAN);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_nx = (frame_len == '0) ? DONE : SCAN;
      end
      SCAN: begin
        if (abort)                  state_nx = IDLE;
        else if (din_valid && last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      hist        <= '0;
      seen        <= '0;
      cnt         <= '0;
      match       <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      match <= hit;
      if (go) begin
        if (!go_zero) begin
          pat_q <= pattern;
          len_q <= frame_len;
          hist  <= '0;
          seen  <= '0;
          cnt   <= '0;
        end
        match_count <= '0;
        overflow    <= 1'b0;
      end
      if (take) begin
        hist <= hist_nx;
        seen <= seen_nx;
        cnt  <= cnt + FRAME_W'(1);
        // saturate rather than wrap; overflow stays set until next start
        if (hit) begin
          if (&match_count) overflow    <= 1'b1;
          else              match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: vector table, corner sequences, and
// randomized scans against a queue-based reference model.
module tb_pattern_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, din, din_valid;
  logic [3:0] pattern;
  logic [1:0] pat2;
  logic [7:0] frame_len;
  logic       din_ready, busy, match, overflow, done;
  logic [7:0] match_count;
  logic       s_ready, s_busy, s_match, s_ovf, s_done;
  logic [1:0] s_count;

  pattern_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .frame_len(frame_len), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .busy(busy),
    .match(match), .match_count(match_count), .overflow(overflow),
    .done(done)
  );

  pattern_scan_ctrl #(.PAT_LEN(2), .FRAME_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pat2), .frame_len(frame_len), .din(din),
    .din_valid(din_valid), .din_ready(s_ready), .busy(s_busy),
    .match(s_match), .match_count(s_count), .overflow(s_ovf),
    .done(s_done)
  );

  int errors = 0;
  int checks = 0;

  // reference model: frame as a queue of accepted bits
  bit       m_scan, m_fin, m_ovf, e_match, m_acc;
  bit       q[$];
  logic [3:0] m_pat;
  int       m_len, m_count;
  int       n_match, n_done;

  typedef struct {
    logic [3:0]  pat;
    int          len;
    logic [15:0] seq;
    bit          gap;
    int          exp_cnt;
    int          exp_match;
    int          exp_done;
  } vec_t;
  vec_t tbl[5];

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endfunction

  function automatic bit tail_matches();
    int n = q.size();
    for (int j = 0; j < 4; j++)
      if (q[n-4+j] != m_pat[3-j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    e_match = 0;
    m_acc   = 0;
    if (reset) begin
      m_scan = 0; m_fin = 0; q.delete(); m_count = 0; m_ovf = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_scan) begin
      if (start) begin
        m_count = 0;
        m_ovf   = 0;
        if (frame_len == 0) m_fin = 1;
        else begin
          m_scan = 1;
          m_pat  = pattern;
          m_len  = frame_len;
          q.delete();
        end
      end
    end else if (abort) begin
      m_scan = 0;
    end else if (din_valid) begin
      m_acc = 1;
      q.push_back(din);
      if (q.size() >= 4 && tail_matches()) begin
        e_match = 1;
        if (m_count == 255) m_ovf = 1;
        else                m_count++;
      end
      if (q.size() == m_len) begin
        m_scan = 0;
        m_fin  = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", busy, m_scan || m_fin);
    chk("din_ready", din_ready, m_scan);
    chk("match", match, e_match);
    chk("done", done, m_fin);
    chk("match_count", match_count, m_count);
    chk("overflow", overflow, m_ovf);
    if (match) n_match++;
    if (done)  n_done++;
  endtask

  task automatic feed(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = bits[i];
      din_valid = 1;
      cyc();
    end
    din_valid = 0;
  endtask

  task automatic run_scan(input logic [3:0] pat, input int len,
                          input logic [15:0] seq, input bit gap);
    int idx = 0;
    int pos;
    bit ph = 0;
    n_match = 0;
    n_done  = 0;
    start = 1; pattern = pat; frame_len = 8'(len); din_valid = 0;
    cyc();
    start = 0; pattern = ~pat; frame_len = 8'hff;
    for (int k = 0; k < 100 && (m_scan || m_fin); k++) begin
      din_valid = gap ? ph : 1'b1;
      ph = ~ph;
      pos = len - 1 - idx;
      if (pos < 0) pos = 0;
      din = seq[pos];
      cyc();
      if (m_acc) idx++;
    end
    din_valid = 0;
    if (m_scan || m_fin) chk("scan_timeout", 1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1011, 7, 16'b1011011, 1'b0, 2, 2, 1};
    tbl[1] = '{4'b1011, 6, 16'b110110,  1'b1, 1, 1, 1};
    tbl[2] = '{4'b0000, 5, 16'b00000,   1'b0, 2, 2, 1};
    tbl[3] = '{4'b1111, 3, 16'b111,     1'b0, 0, 0, 1};
    tbl[4] = '{4'b1011, 0, 16'b0,       1'b0, 0, 0, 1};

    reset = 1; start = 0; abort = 0; din = 0; din_valid = 0;
    pattern = 0; pat2 = 2'b11; frame_len = 0;
    cyc();
    cyc();
    reset = 0;
    cyc();

    foreach (tbl[i]) begin
      run_scan(tbl[i].pat, tbl[i].len, tbl[i].seq, tbl[i].gap);
      chk("tbl_count", match_count, tbl[i].exp_cnt);
      chk("tbl_matches", n_match, tbl[i].exp_match);
      chk("tbl_done", n_done, tbl[i].exp_done);
      chk("tbl_ready_after", din_ready, 0);
    end

    // abort after three bits, then a clean restart
    n_match = 0; n_done = 0;
    start = 1; pattern = 4'b1011; frame_len = 7;
    cyc();
    start = 0;
    feed(8'b101, 3);
    abort = 1; din_valid = 1; din = 1;
    cyc();
    abort = 0; din_valid = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", n_done, 0);
    chk("abort_count", match_count, 0);
    cyc();
    run_scan(4'b1011, 7, 16'b1011011, 0);
    chk("restart_count", match_count, 2);

    // abort coinciding with the final bit
    n_match = 0; n_done = 0;
    start = 1; pattern = 4'b1011; frame_len = 4;
    cyc();
    start = 0;
    feed(8'b101, 3);
    abort = 1; din_valid = 1; din = 1;
    cyc();
    abort = 0; din_valid = 0;
    cyc();
    chk("abort_last_match", n_match, 0);
    chk("abort_last_done", n_done, 0);

    // reset mid-scan with one match counted
    start = 1; pattern = 4'b1011; frame_len = 10;
    cyc();
    start = 0;
    feed(8'b10110, 5);
    chk("pre_reset_count", match_count, 1);
    reset = 1; start = 1; din_valid = 1; din = 1;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_count", match_count, 0);
    cyc();
    chk("rst_start_ignored", busy, 0);
    reset = 0; start = 0; din_valid = 0;
    cyc();

    // two-bit counter saturation on the narrow instance
    pat2 = 2'b11;
    start = 1; pattern = 4'b1111; frame_len = 6;
    cyc();
    start = 0;
    for (int k = 1; k <= 6; k++) begin
      din = 1; din_valid = 1;
      cyc();
      chk("sat_count", s_count, (k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1));
      chk("sat_ovf", s_ovf, (k - 1 >= 4));
      chk("sat_match", s_match, (k >= 2));
      chk("sat_done", s_done, (k == 6));
      chk("sat_ready", s_ready, (k < 6));
      chk("sat_busy", s_busy, 1);
    end
    din_valid = 0;
    cyc();
    chk("sat_hold_count", s_count, 3);
    chk("sat_hold_ovf", s_ovf, 1);

    // randomized scans with gaps, stray starts and rare aborts
    for (int s = 0; s < 30; s++) begin
      for (int w = $urandom_range(0, 2); w > 0; w--) cyc();
      start = 1; pattern = 4'($urandom);
      frame_len = 8'($urandom_range(0, 20));
      cyc();
      for (int k = 0; k < 200 && (m_scan || m_fin); k++) begin
        din       = 1'($urandom);
        din_valid = ($urandom_range(0, 3) != 0);
        abort     = ($urandom_range(0, 40) == 0);
        start     = 1'($urandom);
        pattern   = 4'($urandom);
        frame_len = 8'($urandom);
        cyc();
      end
      start = 0; abort = 0; din_valid = 0;
      if (m_scan || m_fin) chk("rand_timeout", 1, 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
